// File: rtl/poly_load.sv
// poly_load: assembles a serial coefficient stream into packed operand pairs a/b for the polynomial adder.
// Define POLY_LOAD_DBUF_EN for a two-entry pair buffer; otherwise a single buffer is used.
module poly_load #(
  parameter int D = 4,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_coef,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [D*N-1:0] a,
  output logic [D*N-1:0] b
);
`ifdef POLY_LOAD_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif
  localparam int IW = $clog2(D);
  typedef enum logic [1:0] {LOAD_A, LOAD_B, FULL} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [D*N-1:0] a_buf_q, a_buf_d, b_buf_q, b_buf_d, a_q, a_d, b_q, b_d;
  logic hv_q, hv_d, beat, pop, last, complete, take;
  assign beat = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign last = idx_q == IW'(D - 1);
  assign complete = beat & last & (state_q == LOAD_B);
  // The held pair is refilled either straight from a completing load or, with two entries, from the pending one.
  assign take = (complete & (!DBUF | !hv_q | pop)) | (DBUF & (state_q == FULL) & pop);
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= LOAD_A;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (state_q == LOAD_A && beat && last) state_d = LOAD_B;
    if (complete) state_d = (!DBUF || (hv_q && !pop)) ? FULL : LOAD_A;
    if (state_q == FULL && pop) state_d = LOAD_A;
    if (clr) state_d = LOAD_A;
  end
  always_comb begin
    in_ready = state_q != FULL;
    out_valid = hv_q;
    a = a_q;
    b = b_q;
  end
  always_comb begin
    a_buf_d = a_buf_q;
    b_buf_d = b_buf_q;
    if (beat && state_q == LOAD_A) a_buf_d[int'(idx_q)*N +: N] = in_coef;
    if (beat && state_q == LOAD_B) b_buf_d[int'(idx_q)*N +: N] = in_coef;
    if (clr) begin
      a_buf_d = '0;
      b_buf_d = '0;
    end
    idx_d = clr ? '0 : !beat ? idx_q : last ? '0 : idx_q + IW'(1);
    hv_d = clr ? 1'b0 : take ? 1'b1 : pop ? 1'b0 : hv_q;
    a_d = clr ? '0 : take ? a_buf_q : a_q;
    b_d = clr ? '0 : take ? b_buf_d : b_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx_q <= '0;
      hv_q <= 1'b0;
      a_buf_q <= '0;
      b_buf_q <= '0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      idx_q <= idx_d;
      hv_q <= hv_d;
      a_buf_q <= a_buf_d;
      b_buf_q <= b_buf_d;
      a_q <= a_d;
      b_q <= b_d;
    end
endmodule

// File: doc/poly_load.md
# poly_load

Upstream feeder for the combinational polynomial adder. Accepts a serial stream of N-bit coefficients over a valid/ready handshake and assembles two packed D-coefficient operands, a then b. It presents the completed pair to the adder with an output valid/ready handshake, holding it stable until it is consumed. Coefficient k sits at bits [k*N +: N] of each operand, the same packing the adder uses.

## Interface
- D, 4, coefficients per polynomial (D ≥ 2)
- N, 4, bits per coefficient
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear: discards partial and buffered pairs
- in_valid  in  1  in_coef carries a coefficient
- in_ready  out  1  block can accept a coefficient this cycle
- in_coef  in  N  coefficient value
- out_valid  out  1  a/b hold a complete pair
- out_ready  in  1  consumer takes the pair this cycle
- a  out  D*N  packed operand a, coefficient 0 in LSBs
- b  out  D*N  packed operand b, coefficient 0 in LSBs

## Operation
- Beat accepted ⇔ in_valid & in_ready at a rising edge. Pair popped ⇔ out_valid & out_ready at a rising edge.
- Beat counter idx runs 0..D-1.
- States:
  - LOAD_A: beat → a_buf[idx*N +: N]; at idx = D-1 go to LOAD_B, idx → 0.
  - LOAD_B: beat → b_buf likewise; at idx = D-1 the pair is complete, go to FULL, idx → 0.
  - FULL: in_ready = 0; a pop → LOAD_A.
- in_ready = 1 in LOAD_A and LOAD_B, 0 in FULL. It is registered-state derived, with no combinational path from out_ready.
- a and b are registered copies of the completed pair. They are unchanged while out_valid is high and out_ready is low.
- Coefficients are stored verbatim. No modular reduction, no width change.
- clr has priority over both handshakes in the same cycle: state → LOAD_A, idx → 0, out_valid → 0, a/b → 0. A beat or pop presented in that cycle is ignored.
- rst mid-operation: a partial pair is lost, identical to clr but asynchronous.

## Timing
- Reset values:
  - in_ready = 1
  - out_valid = 0
  - a = 0
  - b = 0
  - state = LOAD_A
  - idx = 0
- Latency: out_valid rises in the cycle after the 2D-th accepted beat. a/b are valid in that same cycle.
- Single-buffer throughput: at best one pair per 2D+1 cycles. in_ready rises the cycle after a pop.
- Back-to-back beats with in_valid held high: one beat per cycle, with no bubble between the a and b phases.
- Gaps on in_valid stall idx. There is no timeout.
- out_valid, once high, stays high until popped or cleared. The data is never withdrawn.

## Configuration
- POLY_LOAD_DBUF_EN defined: a two-entry pair buffer.
  - Loading of the next pair continues while the oldest pair is held on a/b.
  - in_ready = 0 only when both entries are full.
  - A pop and the completion of a pair in the same cycle are both honoured: the newly completed pair becomes the held pair the next cycle, and out_valid stays 1.
  - Sustained throughput is one pair per 2D cycles.
- POLY_LOAD_DBUF_EN undefined: single buffer, FSM exactly as above. in_ready = 0 whenever out_valid = 1.

## Test plan
- Reset, then D=4, N=4, stream F,5,A,A then F,5,A,A with out_ready=0 -> out_valid=1 the cycle after beat 8, a=16'hAA5F, b=16'hAA5F, in_ready=0, outputs stable for 5 idle cycles.
- Pop with out_ready=1 -> out_valid=0 and in_ready=1 the next cycle. The next pair 1,2,3,4 / 8,7,6,5 gives a=16'h4321, b=16'h5678.
- Random in_valid gaps (roughly 50%) across 20 pairs -> every a/b matches the scoreboard, and no beat is lost or duplicated.
- clr asserted after 5 beats, then 8 fresh beats 0..7 -> a=16'h3210, b=16'h7654. The earlier partial data never appears.
- Async rst asserted mid-b-phase, not aligned to clk -> out_valid=0, a=b=0, in_ready=1 immediately. The reload afterwards is correct.
- DBUF_EN: stream 16 beats with out_ready=0 -> in_ready drops after beat 16. Pop on the cycle beat 16 completes -> the second pair presents the next cycle and out_valid does not drop.
